map_renderer_multi: RTL

- Parametrised successor to the single-ball map sprite.
- Renders the tile map, up to NUM_BALLS ball discs and NUM_DOTS aim dots for the active ball, producing a 24-bit RGB pixel stream aligned to hcount/vcount.
- Adds a runtime map write port for course editing and hole changes.
- Computes aim-dot positions with a per-frame sequential multiplier FSM instead of wide combinational multipliers.
- Sits between the video timing generator and the HDMI/TMDS encoder.

---
 rtl/map_renderer_multi.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/map_renderer_multi.sv
// Tile-map renderer with multiple ball discs and aim dots; 3-cycle pipeline from hcount/vcount to RGB.
// Aim-dot positions are recomputed once per frame by a small accumulate-and-shift FSM.
module map_renderer_multi #(
    parameter int TILE_LOG2 = 3,
    parameter int MAP_W     = 160,
    parameter int MAP_H     = 90,
    parameter int NUM_BALLS = 2,
    parameter int NUM_DOTS  = 3,
    parameter int DOT_STEP  = 30,
    parameter int FRAC      = 5,
    parameter int BALL_D    = 8,
    parameter int V_ACTIVE  = 720,
    localparam int BSEL_W   = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1,
    localparam int ADDR_W   = $clog2(MAP_W * MAP_H)
) (
    input  logic                      pixel_clk_in,
    input  logic                      rst_in,
    input  logic [10:0]               hcount_in,
    input  logic [9:0]                vcount_in,
    input  logic [16*NUM_BALLS-1:0]   ballx_in,
    input  logic [16*NUM_BALLS-1:0]   bally_in,
    input  logic [NUM_BALLS-1:0]      ball_valid_in,
    input  logic [BSEL_W-1:0]         active_ball_in,
    input  logic [15:0]               cos_abs_in,
    input  logic [15:0]               sin_abs_in,
    input  logic                      cos_sign_in,
    input  logic                      sin_sign_in,
    input  logic                      grass_color_in,
    input  logic                      map_we_in,
    input  logic [ADDR_W-1:0]         map_addr_in,
    input  logic [3:0]                map_data_in,
    output logic [7:0]                red_out,
    output logic [7:0]                green_out,
    output logic [7:0]                blue_out,
    output logic [10:0]               hcount_out,
    output logic [9:0]                vcount_out
);
    localparam int T         = 1 << TILE_LOG2;
    localparam int MAP_CELLS = MAP_W * MAP_H;
    localparam int IDX_W     = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
    localparam logic [23:0] WALL = 24'h8B4F39;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic in_disc(input int u, input int v, input int d);
        int a;
        int b;
        a = 2 * u - d + 1;
        b = 2 * v - d + 1;
        return (a * a + b * b) <= (d * d);
    endfunction

    function automatic logic ball_covers(input int h, input int v, input int bx, input int by);
        int u;
        int w;
        u = h - bx + BALL_D / 2 - 1;
        w = v - by + BALL_D / 2 - 1;
        return (u >= 0) && (u < BALL_D) && (w >= 0) && (w < BALL_D) && in_disc(u, w, BALL_D);
    endfunction

    logic [3:0]  map_ram [MAP_CELLS];
    logic [3:0]  tile_code1;
    logic        in_map_in;
    logic [31:0] rd_addr_full;
    logic [10:0] h1;
    logic [9:0]  v1;
    logic        in_map1;
    logic [10:0] h2;
    logic [9:0]  v2;
    logic [23:0] rgb2;

    assign in_map_in    = (int'(hcount_in) < MAP_W * T) && (int'(vcount_in) < MAP_H * T);
    assign rd_addr_full = 32'(vcount_in >> TILE_LOG2) * 32'(MAP_W) + 32'(hcount_in >> TILE_LOG2);

    // Read-first: the read samples the array before this cycle's write lands.
    always_ff @(posedge pixel_clk_in) begin
        if (map_we_in && (int'(map_addr_in) < MAP_CELLS)) begin
            map_ram[map_addr_in] <= map_data_in;
        end
        tile_code1 <= in_map_in ? map_ram[rd_addr_full[ADDR_W-1:0]] : 4'd0;
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] step_idx;
    logic [31:0]      acc_x, acc_y, inc_x, inc_y, next_acc_x, next_acc_y;
    logic [10:0]      base_x, sel_x, dx, nx;
    logic [9:0]       base_y, sel_y, dy, ny;
    logic             sgn_x, sgn_y;
    logic [10:0]      stage_x [NUM_DOTS];
    logic [9:0]       stage_y [NUM_DOTS];
    logic [10:0]      dot_x   [NUM_DOTS];
    logic [9:0]       dot_y   [NUM_DOTS];
    logic             dots_valid;

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (int'(active_ball_in) == i) begin
                sel_x = ballx_in[16*i+FRAC +: 11];
                sel_y = bally_in[16*i+FRAC +: 10];
            end
        end
    end

    // Step k adds k*DOT_STEP*trig by accumulation, so no wide multiplier per dot.
    assign next_acc_x = acc_x + inc_x;
    assign next_acc_y = acc_y + inc_y;
    assign dx = next_acc_x[18:8];
    assign dy = next_acc_y[17:8];
    assign nx = sgn_x ? base_x + dx : base_x - dx + 11'd1;
    assign ny = sgn_y ? base_y + 10'd1 - dy : base_y + dy;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            step_idx   <= '0;
            acc_x      <= '0;
            acc_y      <= '0;
            inc_x      <= '0;
            inc_y      <= '0;
            base_x     <= '0;
            base_y     <= '0;
            sgn_x      <= 1'b0;
            sgn_y      <= 1'b0;
            dots_valid <= 1'b0;
            for (int k = 0; k < NUM_DOTS; k++) begin
                stage_x[k] <= '0;
                stage_y[k] <= '0;
                dot_x[k]   <= '0;
                dot_y[k]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (vcount_in == 10'(V_ACTIVE) && hcount_in == 11'd0) begin
                        state    <= CALC;
                        step_idx <= '0;
                        acc_x    <= '0;
                        acc_y    <= '0;
                        inc_x    <= 32'(cos_abs_in) * 32'(DOT_STEP);
                        inc_y    <= 32'(sin_abs_in) * 32'(DOT_STEP);
                        base_x   <= sel_x;
                        base_y   <= sel_y;
                        sgn_x    <= cos_sign_in;
                        sgn_y    <= sin_sign_in;
                    end
                end
                CALC: begin
                    acc_x             <= next_acc_x;
                    acc_y             <= next_acc_y;
                    stage_x[step_idx] <= nx;
                    stage_y[step_idx] <= ny;
                    if (step_idx == IDX_W'(NUM_DOTS - 1)) begin
                        state <= DONE;
                    end else begin
                        step_idx <= step_idx + 1'b1;
                    end
                end
                DONE: begin
                    for (int k = 0; k < NUM_DOTS; k++) begin
                        dot_x[k] <= stage_x[k];
                        dot_y[k] <= stage_y[k];
                    end
                    dots_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [23:0] tile_rgb, base_rgb, pix_rgb;
    logic        split_ok, ball_hit, dot_hit;
    int          lx, ly;

    assign lx       = int'(h1[TILE_LOG2-1:0]);
    assign ly       = int'(v1[TILE_LOG2-1:0]);
    assign base_rgb = tile_code1[0] ? (grass_color_in ? 24'h9C972C : 24'hB0AA28)
                                    : (grass_color_in ? 24'h7CFC00 : 24'h73DE0B);

    always_comb begin
        split_ok = 1'b1;
        case (tile_code1)
            4'd4, 4'd5:   split_ok = (lx + ly) < T;
            4'd6, 4'd7:   split_ok = lx < ly;
            4'd8, 4'd9:   split_ok = (lx + ly) >= T;
            4'd10, 4'd11: split_ok = lx >= ly;
            default:      split_ok = 1'b1;
        endcase
        if (tile_code1 == 4'd0) begin
            tile_rgb = in_disc(lx, ly, T) ? 24'h000000 : 24'h7CFC00;
        end else if (tile_code1 >= 4'd2 && tile_code1 <= 4'd11) begin
            tile_rgb = split_ok ? base_rgb : WALL;
        end else begin
            tile_rgb = WALL;
        end
    end

    // All balls share one colour, so OR-ing the hits gives the same result as lowest-index priority.
    always_comb begin
        ball_hit = 1'b0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (ball_valid_in[i] && ball_covers(int'(h1), int'(v1),
                                                int'(ballx_in[16*i+FRAC +: 16-FRAC]),
                                                int'(bally_in[16*i+FRAC +: 16-FRAC]))) begin
                ball_hit = 1'b1;
            end
        end
        dot_hit = 1'b0;
        for (int k = 0; k < NUM_DOTS; k++) begin
            if (dots_valid && h1 == dot_x[k] && v1 == dot_y[k]) begin
                dot_hit = 1'b1;
            end
        end
        pix_rgb = dot_hit ? 24'h0000FF : ball_hit ? 24'hFFFFFF : in_map1 ? tile_rgb : 24'h000000;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            h1         <= '0;
            v1         <= '0;
            in_map1    <= 1'b0;
            h2         <= '0;
            v2         <= '0;
            rgb2       <= '0;
            red_out    <= '0;
            green_out  <= '0;
            blue_out   <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
        end else begin
            h1         <= hcount_in;
            v1         <= vcount_in;
            in_map1    <= in_map_in;
            h2         <= h1;
            v2         <= v1;
            rgb2       <= pix_rgb;
            {red_out, green_out, blue_out} <= rgb2;
            hcount_out <= h2;
            vcount_out <= v2;
        end
    end
endmodule
